// File: rtl/fp_mant_addsub_norm_if.sv
// Operand/result bundle for the FP mantissa add/sub + normalize-detect core.
// Inputs: in_valid, ma, mb, sa, sb, e_in. Outputs: out_valid, m_sum, sign, e_out, sh, norm_right, zero.
interface fp_mant_addsub_norm_if #(
    parameter int WIDTH = 25
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic             sa;
    logic             sb;
    logic [7:0]       e_in;

    logic             out_valid;
    logic [WIDTH-1:0] m_sum;
    logic             sign;
    logic [7:0]       e_out;
    logic [SHW-1:0]   sh;
    logic             norm_right;
    logic             zero;

    modport master (
        output in_valid, ma, mb, sa, sb, e_in,
        input  out_valid, m_sum, sign, e_out, sh, norm_right, zero
    );

    modport slave (
        input  in_valid, ma, mb, sa, sb, e_in,
        output out_valid, m_sum, sign, e_out, sh, norm_right, zero
    );
endinterface

// File: rtl/fp_mant_addsub_norm.sv
// Two-stage mantissa add/subtract with leading-one detect for the SP FP adder.
// Ports: clk, rst_n (async active-low), bus (slave): operands in, sum/sign/shift/zero out.
module fp_mant_addsub_norm #(
    parameter int WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_mant_addsub_norm_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    // Stage 1 state
    logic             v1_d, v1_q;
    logic [WIDTH-1:0] m1_d, m1_q;
    logic [WIDTH-1:0] m2_d, m2_q;
    logic             s1_d, s1_q;
    logic [7:0]       e1_d, e1_q;

    // Stage 2 state
    logic             v2_d, v2_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             s2_d, s2_q;
    logic [7:0]       e2_d, e2_q;
    logic [SHW-1:0]   sh_d, sh_q;
    logic             nr_d, nr_q;
    logic             z_d, z_q;

    logic             a_lt_b;
    logic             diff;
    logic [SHW-1:0]   msb;

    // Complement the smaller magnitude so the sum is |a - b|;
    // equal magnitudes complement mb and cancel to +0.
    always_comb begin
        a_lt_b = bus.ma < bus.mb;
        diff   = bus.sa ^ bus.sb;
        m1_d   = bus.ma;
        m2_d   = bus.mb;
        if (diff && a_lt_b) begin
            m1_d = ~bus.ma + WIDTH'(1);
        end
        if (diff && !a_lt_b) begin
            m2_d = ~bus.mb + WIDTH'(1);
        end
        s1_d = a_lt_b ? bus.sb : bus.sa;
        if (diff && (bus.ma == bus.mb)) begin
            s1_d = 1'b0;
        end
        e1_d = bus.e_in;
        v1_d = bus.in_valid;
    end

    // Carry out of the top bit is dropped on purpose.
    always_comb begin
        sum_d = m1_q + m2_q;
        msb   = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (sum_d[i]) begin
                msb = i[SHW-1:0];
            end
        end
        sh_d = '0;
        nr_d = 1'b0;
        z_d  = 1'b0;
        if (sum_d[WIDTH-1]) begin
            nr_d = 1'b1;
            sh_d = SHW'(1);
        end else if (sum_d == '0) begin
            z_d = 1'b1;
        end else begin
            sh_d = SHW'(WIDTH - 2) - msb;
        end
        s2_d = s1_q;
        e2_d = e1_q;
        v2_d = v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            m1_q  <= '0;
            m2_q  <= '0;
            s1_q  <= 1'b0;
            e1_q  <= '0;
            v2_q  <= 1'b0;
            sum_q <= '0;
            s2_q  <= 1'b0;
            e2_q  <= '0;
            sh_q  <= '0;
            nr_q  <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            m1_q  <= m1_d;
            m2_q  <= m2_d;
            s1_q  <= s1_d;
            e1_q  <= e1_d;
            v2_q  <= v2_d;
            sum_q <= sum_d;
            s2_q  <= s2_d;
            e2_q  <= e2_d;
            sh_q  <= sh_d;
            nr_q  <= nr_d;
            z_q   <= z_d;
        end
    end

    assign bus.out_valid  = v2_q;
    assign bus.m_sum      = sum_q;
    assign bus.sign       = s2_q;
    assign bus.e_out      = e2_q;
    assign bus.sh         = sh_q;
    assign bus.norm_right = nr_q;
    assign bus.zero       = z_q;
endmodule

// File: tb/tb_fp_mant_addsub_norm.sv
// Randomized self-checking bench for fp_mant_addsub_norm.
// Reference model works on signed magnitudes with plain integer arithmetic.
module tb_fp_mant_addsub_norm;
    logic clk;
    logic rst_n;

    fp_mant_addsub_norm_if #(.WIDTH(25)) bus ();

    fp_mant_addsub_norm #(.WIDTH(25)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [24:0] m;
        logic        s;
        logic [7:0]  e;
        logic [4:0]  sh;
        logic        nr;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic v, input logic [24:0] a,
                                   input logic [24:0] b, input logic s_a,
                                   input logic s_b, input logic [7:0] e);
        exp_t r;
        longint unsigned x, y, sum, t;
        x = a;
        y = b;
        if (s_a == s_b) begin
            sum = (x + y) % (64'd1 << 25);
            r.s = s_a;
        end else if (x > y) begin
            sum = x - y;
            r.s = s_a;
        end else if (y > x) begin
            sum = y - x;
            r.s = s_b;
        end else begin
            sum = 0;
            r.s = 1'b0;
        end
        r.v  = v;
        r.m  = sum[24:0];
        r.e  = e;
        r.sh = 5'd0;
        r.nr = 1'b0;
        r.z  = 1'b0;
        if (sum >= (64'd1 << 24)) begin
            r.nr = 1'b1;
            r.sh = 5'd1;
        end else if (sum == 0) begin
            r.z = 1'b1;
        end else begin
            t = sum;
            while (t < (64'd1 << 23)) begin
                t = t * 2;
                r.sh = r.sh + 5'd1;
            end
        end
        return r;
    endfunction

    task automatic compare(input exp_t x);
        chk("out_valid", 32'(bus.out_valid), 32'(x.v));
        chk("m_sum", 32'(bus.m_sum), 32'(x.m));
        chk("sign", 32'(bus.sign), 32'(x.s));
        chk("e_out", 32'(bus.e_out), 32'(x.e));
        chk("sh", 32'(bus.sh), 32'(x.sh));
        chk("norm_right", 32'(bus.norm_right), 32'(x.nr));
        chk("zero", 32'(bus.zero), 32'(x.z));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_m_sum"}, 32'(bus.m_sum), 32'd0);
        chk({tag, "_sign"}, 32'(bus.sign), 32'd0);
        chk({tag, "_e_out"}, 32'(bus.e_out), 32'd0);
        chk({tag, "_sh"}, 32'(bus.sh), 32'd0);
        chk({tag, "_nr"}, 32'(bus.norm_right), 32'd0);
        chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
    endtask

    // Stage-1 reset contents behave like an all-zero, invalid operand set.
    task automatic restart_model();
        exp_q.delete();
        exp_q.push_back(model(1'b0, 25'd0, 25'd0, 1'b0, 1'b0, 8'd0));
    endtask

    task automatic cyc(input logic v, input logic [24:0] a,
                       input logic [24:0] b, input logic s_a,
                       input logic s_b, input logic [7:0] e);
        bus.in_valid = v;
        bus.ma       = a;
        bus.mb       = b;
        bus.sa       = s_a;
        bus.sb       = s_b;
        bus.e_in     = e;
        exp_q.push_back(model(v, a, b, s_a, s_b, e));
        @(posedge clk);
        #1;
        compare(exp_q.pop_front());
    endtask

    task automatic flush();
        repeat (2) cyc(1'b0, 25'd0, 25'd0, 1'b0, 1'b0, 8'd0);
    endtask

    function automatic logic [24:0] rand_mant();
        logic [24:0] m;
        m = 25'h0800000 | 25'($urandom_range(0, 32'h7FFFFF));
        if ($urandom_range(0, 2) == 0) begin
            m = m >> $urandom_range(0, 24);
        end
        return m;
    endfunction

    initial begin
        logic [24:0] a, b;
        n_chk  = 0;
        n_fail = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.ma       = '0;
        bus.mb       = '0;
        bus.sa       = 1'b0;
        bus.sb       = 1'b0;
        bus.e_in     = '0;
        #2;
        check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        restart_model();

        cyc(1'b1, 25'h0800000, 25'h0800000, 1'b0, 1'b0, 8'h7F);
        cyc(1'b1, 25'h0C00000, 25'h0800000, 1'b0, 1'b1, 8'h80);
        cyc(1'b1, 25'h0800000, 25'h0C00000, 1'b0, 1'b1, 8'h81);
        cyc(1'b1, 25'h0A00000, 25'h0A00000, 1'b1, 1'b0, 8'h10);
        cyc(1'b1, 25'h0000000, 25'h0800000, 1'b1, 1'b0, 8'h20);
        cyc(1'b1, 25'h0800001, 25'h0800000, 1'b0, 1'b1, 8'h30);
        cyc(1'b1, 25'h0FFFFFF, 25'h0FFFFFF, 1'b1, 1'b1, 8'hFE);
        cyc(1'b1, 25'h0000000, 25'h0000000, 1'b1, 1'b1, 8'h00);
        flush();

        for (int i = 0; i < 400; i++) begin
            a = rand_mant();
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a ^ 25'($urandom_range(0, 15));
                2: b = 25'd0;
                default: b = rand_mant();
            endcase
            cyc(1'($urandom_range(0, 1)), a, b, 1'($urandom),
                1'($urandom), 8'($urandom));
        end

        cyc(1'b1, 25'h0C00000, 25'h0800000, 1'b0, 1'b1, 8'h55);
        cyc(1'b1, 25'h0800000, 25'h0C00000, 1'b0, 1'b1, 8'h66);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        check_all_zero("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        restart_model();
        cyc(1'b0, 25'h0800000, 25'h0400000, 1'b0, 1'b0, 8'h01);
        cyc(1'b1, 25'h0900000, 25'h0100000, 1'b0, 1'b1, 8'h02);
        cyc(1'b0, 25'h0000000, 25'h0000000, 1'b0, 1'b0, 8'h00);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mant_addsub_norm.md
Name: fp_mant_addsub_norm

Overview:
- Mantissa add/subtract and normalization-detect core of the single-precision FP adder, placed between exponent alignment and final normalize/exponent-adjust.
- Takes two aligned 25-bit extended mantissas (format 01.xxx; bit 23 is the hidden one, bit 24 is carry headroom) and their signs.
- When signs differ, it two's-complements the smaller-magnitude operand and adds.
- Reports the raw sum, result sign, normalization shift amount/direction and a zero flag.
- 2-stage pipeline.

Parameters:
- WIDTH, 25, extended mantissa width; the shift field is 5 bits for the default width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand qualifier
- ma  input  25  aligned extended mantissa of A
- mb  input  25  aligned extended mantissa of B
- sa  input  1  sign of A
- sb  input  1  sign of B
- e_in  input  8  common (larger) exponent, passed through
- out_valid  output  1  result qualifier
- m_sum  output  25  raw mantissa sum, modulo 2^25
- sign  output  1  result sign
- e_out  output  8  e_in delayed by 2 cycles
- sh  output  5  normalization shift amount
- norm_right  output  1  1 = shift right by 1 and increment exponent; 0 = shift left by sh and decrement exponent by sh
- zero  output  1  m_sum is all zero

Behaviour:
- Reset: the single clock is clk. rst_n low asynchronously clears all pipeline registers, and all outputs read 0. Any in-flight data is discarded and out_valid stays 0 until new valid inputs propagate.
- Latency is exactly 2 cycles: inputs sampled at edge N appear on outputs after edge N+1. Fully pipelined, one new operand set accepted per cycle.
- No stall or back-pressure. in_valid only travels alongside the data; the datapath registers update every cycle regardless of in_valid.
- Stage 1 (compare/complement, registered):
  - a_lt_b = (ma < mb), unsigned.
  - diff = sa ^ sb.
  - m1 = (diff & a_lt_b) ? (~ma + 1) mod 2^25 : ma.
  - m2 = (diff & !a_lt_b) ? (~mb + 1) mod 2^25 : mb.
  - Equal magnitudes with differing signs complement mb.
  - Sign: a_lt_b ? sb : sa, except when diff & (ma == mb), where sign = 0 (exact cancellation gives +0).
  - e_in and in_valid are registered alongside.
- Stage 2 (add/detect, registered):
  - m_sum = (m1 + m2) mod 2^25; the carry out of bit 24 is discarded (this yields |difference| when signs differ).
  - If m_sum[24] = 1: norm_right = 1, sh = 1.
  - Else if m_sum != 0: p = index of the highest set bit (0..23); norm_right = 0, sh = 23 − p. sh = 0 means already normalized.
  - If m_sum == 0: zero = 1, sh = 0, norm_right = 0.
  - Zero operands arrive as all-zero mantissas and need no special handling: compl2(0) = 0.
  - sign and e_out are pipelined unchanged from stage 1.

Test Plan:
- Same sign 1.0 + 1.0: ma = mb = 0x0800000, sa = sb = 0, e_in = 0x7F -> 2 cycles later m_sum = 0x1000000, norm_right = 1, sh = 1, sign = 0, e_out = 0x7F, out_valid = 1.
- 1.5 − 1.0: ma = 0x0C00000, sa = 0, mb = 0x0800000, sb = 1 -> m_sum = 0x0400000, sh = 1, norm_right = 0, sign = 0.
- 1.0 − 1.5 (smaller is A): ma = 0x0800000, sa = 0, mb = 0x0C00000, sb = 1 -> m_sum = 0x0400000, sh = 1, sign = 1.
- Cancellation and zero operand:
  - ma = mb = 0x0A00000, sa = 1, sb = 0 -> m_sum = 0, zero = 1, sh = 0, sign = 0.
  - ma = 0, sa = 1, mb = 0x0800000, sb = 0 -> m_sum = 0x0800000, sh = 0, sign = 0.
- Deep cancellation: ma = 0x0800001, mb = 0x0800000, sa = 0, sb = 1 -> m_sum = 0x0000001, sh = 23, norm_right = 0, sign = 0.
- Back-to-back and reset:
  - Issue the first three vectors on consecutive cycles -> results on three consecutive cycles in the same order.
  - Assert rst_n low mid-stream (between clock edges) -> all outputs 0 immediately.
  - Release rst_n -> out_valid stays 0 until the second edge after the next valid input.
